// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter: FSM states, owner
// encoding, default bus widths and stall-controller bit positions.
package mem_arb_pkg;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;
  localparam int STARVE_W   = 8;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_CMD  = 2'd1,
    ARB_RSP  = 2'd2
  } arb_state_e;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  localparam int STALL_BIT_IF  = 0;
  localparam int STALL_BIT_MEM = 3;

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Saturating count of IF arbitrations lost to the LSU; force_if asserts once
// the count reaches MAX_WAIT so the next contested arbitration goes to IF.
module mem_arb_starve_cnt
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic force_if
);

  localparam logic [STARVE_W-1:0] MAX_CNT = STARVE_W'(MAX_WAIT);

  logic [STARVE_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX_CNT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_if = (cnt_q == MAX_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus port between IF and LSU, one transaction in flight.
// Optional grant/starvation counters are built when MEM_PORT_ARB_PERF_EN is defined.
//
// state    | meaning
// ARB_IDLE | nothing in flight; arbitrate and capture winner's command
// ARB_CMD  | bus_req high with a stable command, waiting for bus_gnt
// ARB_RSP  | command accepted, waiting for bus_rvalid
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = ARB_ADDR_W,
  parameter int DATA_W   = ARB_DATA_W,
  parameter int MAX_WAIT = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_be,
  output logic                ls_gnt,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_be,
  input  logic                bus_gnt,
  input  logic                bus_rvalid,
  input  logic [DATA_W-1:0]   bus_rdata,
  output logic                stall_req_if,
  output logic                stall_req_mem,
  output logic [31:0]         perf_if_cnt,
  output logic [31:0]         perf_ls_cnt,
  output logic [31:0]         perf_starve_cnt
);

  localparam int BE_W = DATA_W / 8;

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [BE_W-1:0]   bus_be_q, bus_be_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              ls_rvalid_q, ls_rvalid_d;
  logic              force_if;

  mem_arb_starve_cnt #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (if_req && ls_gnt),
    .clr      (if_gnt),
    .force_if (force_if)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_be_d    = bus_be_q;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    if_rvalid_d = 1'b0;
    ls_rvalid_d = 1'b0;
    if_gnt      = 1'b0;
    ls_gnt      = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (ls_req && !(force_if && if_req)) begin
          ls_gnt      = 1'b1;
          owner_d     = OWN_LS;
          bus_we_d    = ls_we;
          bus_addr_d  = ls_addr;
          bus_wdata_d = ls_wdata;
          bus_be_d    = ls_be;
          state_d     = ARB_CMD;
        end else if (if_req) begin
          // Fetches are full-word reads.
          if_gnt      = 1'b1;
          owner_d     = OWN_IF;
          bus_we_d    = 1'b0;
          bus_addr_d  = if_addr;
          bus_wdata_d = '0;
          bus_be_d    = '1;
          state_d     = ARB_CMD;
        end
      end
      ARB_CMD: begin
        if (bus_gnt) begin
          state_d = ARB_RSP;
        end
      end
      ARB_RSP: begin
        if (bus_rvalid) begin
          if (owner_q == OWN_LS) begin
            ls_rdata_d  = bus_rdata;
            ls_rvalid_d = 1'b1;
          end else begin
            if_rdata_d  = bus_rdata;
            if_rvalid_d = 1'b1;
          end
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWN_IF;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_be_q    <= '0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_be_q    <= bus_be_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
      if_rvalid_q <= if_rvalid_d;
      ls_rvalid_q <= ls_rvalid_d;
    end
  end

  assign bus_req   = (state_q == ARB_CMD);
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_be    = bus_be_q;
  assign if_rdata  = if_rdata_q;
  assign ls_rdata  = ls_rdata_q;
  assign if_rvalid = if_rvalid_q;
  assign ls_rvalid = ls_rvalid_q;

  assign stall_req_if  = (if_req && !if_gnt) || ((owner_q == OWN_IF) && (state_q != ARB_IDLE));
  assign stall_req_mem = (ls_req && !ls_gnt) || ((owner_q == OWN_LS) && (state_q != ARB_IDLE));

`ifdef MEM_PORT_ARB_PERF_EN
  logic [31:0] perf_if_q, perf_if_d;
  logic [31:0] perf_ls_q, perf_ls_d;
  logic [31:0] perf_starve_q, perf_starve_d;

  // An IF grant while the LSU is also requesting can only come from the override.
  always_comb begin
    perf_if_d     = perf_if_q;
    perf_ls_d     = perf_ls_q;
    perf_starve_d = perf_starve_q;
    if (if_gnt) perf_if_d = perf_if_q + 32'd1;
    if (ls_gnt) perf_ls_d = perf_ls_q + 32'd1;
    if (if_gnt && ls_req) perf_starve_d = perf_starve_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_if_q     <= '0;
      perf_ls_q     <= '0;
      perf_starve_q <= '0;
    end else begin
      perf_if_q     <= perf_if_d;
      perf_ls_q     <= perf_ls_d;
      perf_starve_q <= perf_starve_d;
    end
  end

  assign perf_if_cnt     = perf_if_q;
  assign perf_ls_cnt     = perf_ls_q;
  assign perf_starve_cnt = perf_starve_q;
`else
  assign perf_if_cnt     = '0;
  assign perf_ls_cnt     = '0;
  assign perf_starve_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (MAX_WAIT=2): arbitration
// vectors plus scripted multi-cycle sequences with hand-computed expectations.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [31:0] ls_addr = '0;
  logic [31:0] ls_wdata = '0;
  logic [3:0]  ls_be = '0;
  logic        ls_gnt, ls_rvalid;
  logic [31:0] ls_rdata;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt = 1'b0;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        stall_req_if, stall_req_mem;
  logic [31:0] perf_if_cnt, perf_ls_cnt, perf_starve_cnt;
  logic [3:0]  stall_vec;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .MAX_WAIT (2)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .if_req          (if_req),
    .if_addr         (if_addr),
    .if_gnt          (if_gnt),
    .if_rvalid       (if_rvalid),
    .if_rdata        (if_rdata),
    .ls_req          (ls_req),
    .ls_we           (ls_we),
    .ls_addr         (ls_addr),
    .ls_wdata        (ls_wdata),
    .ls_be           (ls_be),
    .ls_gnt          (ls_gnt),
    .ls_rvalid       (ls_rvalid),
    .ls_rdata        (ls_rdata),
    .bus_req         (bus_req),
    .bus_we          (bus_we),
    .bus_addr        (bus_addr),
    .bus_wdata       (bus_wdata),
    .bus_be          (bus_be),
    .bus_gnt         (bus_gnt),
    .bus_rvalid      (bus_rvalid),
    .bus_rdata       (bus_rdata),
    .stall_req_if    (stall_req_if),
    .stall_req_mem   (stall_req_mem),
    .perf_if_cnt     (perf_if_cnt),
    .perf_ls_cnt     (perf_ls_cnt),
    .perf_starve_cnt (perf_starve_cnt)
  );

  // Stall controller view of the two request lines.
  always_comb begin
    stall_vec = '0;
    stall_vec[STALL_BIT_IF]  = stall_req_if;
    stall_vec[STALL_BIT_MEM] = stall_req_mem;
  end

  typedef struct {
    logic if_req;
    logic ls_req;
    logic exp_if_gnt;
    logic exp_ls_gnt;
    logic exp_stall_if;
    logic exp_stall_mem;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_perf(input string tag, input int e_if, input int e_ls, input int e_st);
`ifdef MEM_PORT_ARB_PERF_EN
    chk({tag, " perf_if"}, perf_if_cnt, 32'(e_if));
    chk({tag, " perf_ls"}, perf_ls_cnt, 32'(e_ls));
    chk({tag, " perf_starve"}, perf_starve_cnt, 32'(e_st));
`else
    chk({tag, " perf_if"}, perf_if_cnt, 32'(e_if * 0));
    chk({tag, " perf_ls"}, perf_ls_cnt, 32'(e_ls * 0));
    chk({tag, " perf_starve"}, perf_starve_cnt, 32'(e_st * 0));
`endif
  endtask

  // Single uncontested read with immediate bus_gnt and bus_rvalid.
  task automatic do_txn(input logic is_ls, input logic [31:0] addr, input logic [31:0] data);
    next_cycle();
    bus_gnt = 1'b1;
    bus_rvalid = 1'b0;
    if (is_ls) begin
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = addr;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    #1;
    chk("txn if_gnt", {31'd0, if_gnt}, {31'd0, !is_ls});
    chk("txn ls_gnt", {31'd0, ls_gnt}, {31'd0, is_ls});
    next_cycle();
    if_req = 1'b0;
    ls_req = 1'b0;
    #1;
    chk("txn bus_req", {31'd0, bus_req}, 32'd1);
    chk("txn bus_addr", bus_addr, addr);
    next_cycle();
    bus_rvalid = 1'b1;
    bus_rdata = data;
    next_cycle();
    bus_rvalid = 1'b0;
    #1;
    if (is_ls) begin
      chk("txn ls_rvalid", {31'd0, ls_rvalid}, 32'd1);
      chk("txn ls_rdata", ls_rdata, data);
    end else begin
      chk("txn if_rvalid", {31'd0, if_rvalid}, 32'd1);
      chk("txn if_rdata", if_rdata, data);
    end
  endtask

  logic exp_arb_ls[5];

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    exp_arb_ls[0] = 1'b1;
    exp_arb_ls[1] = 1'b1;
    exp_arb_ls[2] = 1'b0;
    exp_arb_ls[3] = 1'b1;
    exp_arb_ls[4] = 1'b1;

    // Reset values
    #12;
    chk("rst bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst bus_addr", bus_addr, 32'd0);
    chk("rst bus_wdata", bus_wdata, 32'd0);
    chk("rst bus_be_we", {27'd0, bus_be, bus_we}, 32'd0);
    chk("rst rdata", if_rdata | ls_rdata, 32'd0);
    chk("rst rvalid", {30'd0, if_rvalid, ls_rvalid}, 32'd0);
    chk("rst stall", {28'd0, stall_vec}, 32'd0);
    chk_perf("rst", 0, 0, 0);
    rst_n = 1'b1;

    // Combinational arbitration in IDLE; requests withdrawn before the edge.
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      if_req = vecs[i].if_req;
      ls_req = vecs[i].ls_req;
      if_addr = 32'h0000_0F00;
      ls_addr = 32'h0000_0F80;
      #1;
      chk($sformatf("vec%0d if_gnt", i), {31'd0, if_gnt}, {31'd0, vecs[i].exp_if_gnt});
      chk($sformatf("vec%0d ls_gnt", i), {31'd0, ls_gnt}, {31'd0, vecs[i].exp_ls_gnt});
      chk($sformatf("vec%0d stall_if", i), {31'd0, stall_vec[0]}, {31'd0, vecs[i].exp_stall_if});
      chk($sformatf("vec%0d stall_mem", i), {31'd0, stall_vec[3]}, {31'd0, vecs[i].exp_stall_mem});
      #1;
      if_req = 1'b0;
      ls_req = 1'b0;
    end

    // IF-only read with immediate bus handshakes
    next_cycle();
    if_req = 1'b1; if_addr = 32'h100; bus_gnt = 1'b1;
    #1;
    chk("if1 c0 if_gnt", {31'd0, if_gnt}, 32'd1);
    chk("if1 c0 bus_req", {31'd0, bus_req}, 32'd0);
    chk("if1 c0 stall_if", {31'd0, stall_req_if}, 32'd0);
    next_cycle();
    if_req = 1'b0;
    #1;
    chk("if1 c1 bus_req", {31'd0, bus_req}, 32'd1);
    chk("if1 c1 bus_addr", bus_addr, 32'h100);
    chk("if1 c1 bus_we", {31'd0, bus_we}, 32'd0);
    chk("if1 c1 stall_if", {31'd0, stall_req_if}, 32'd1);
    next_cycle();
    bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    #1;
    chk("if1 c2 bus_req", {31'd0, bus_req}, 32'd0);
    chk("if1 c2 stall_if", {31'd0, stall_req_if}, 32'd1);
    chk("if1 c2 if_rvalid", {31'd0, if_rvalid}, 32'd0);
    next_cycle();
    bus_rvalid = 1'b0;
    #1;
    chk("if1 c3 if_rvalid", {31'd0, if_rvalid}, 32'd1);
    chk("if1 c3 if_rdata", if_rdata, 32'hDEAD_BEEF);
    chk("if1 c3 stall_if", {31'd0, stall_req_if}, 32'd0);
    chk("if1 c3 ls_rvalid", {31'd0, ls_rvalid}, 32'd0);
    next_cycle();
    #1;
    chk("if1 c4 if_rvalid", {31'd0, if_rvalid}, 32'd0);
    chk("if1 c4 if_rdata hold", if_rdata, 32'hDEAD_BEEF);

    // Simultaneous requests: LSU first, IF on the IDLE cycle after ls_rvalid
    next_cycle();
    if_req = 1'b1; if_addr = 32'h104;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h200;
    #1;
    chk("both c0 ls_gnt", {31'd0, ls_gnt}, 32'd1);
    chk("both c0 if_gnt", {31'd0, if_gnt}, 32'd0);
    chk("both c0 stall_if", {31'd0, stall_req_if}, 32'd1);
    chk("both c0 stall_mem", {31'd0, stall_req_mem}, 32'd0);
    next_cycle();
    ls_req = 1'b0;
    #1;
    chk("both c1 bus_addr", bus_addr, 32'h200);
    chk("both c1 if_gnt", {31'd0, if_gnt}, 32'd0);
    chk("both c1 stall_mem", {31'd0, stall_req_mem}, 32'd1);
    chk("both c1 stall_if", {31'd0, stall_req_if}, 32'd1);
    next_cycle();
    bus_rvalid = 1'b1; bus_rdata = 32'h1111_2222;
    #1;
    chk("both c2 if_gnt", {31'd0, if_gnt}, 32'd0);
    next_cycle();
    bus_rvalid = 1'b0;
    #1;
    chk("both c3 ls_rvalid", {31'd0, ls_rvalid}, 32'd1);
    chk("both c3 ls_rdata", ls_rdata, 32'h1111_2222);
    chk("both c3 if_gnt", {31'd0, if_gnt}, 32'd1);
    chk("both c3 if_rdata hold", if_rdata, 32'hDEAD_BEEF);
    next_cycle();
    if_req = 1'b0;
    #1;
    chk("both c4 bus_addr", bus_addr, 32'h104);
    next_cycle();
    bus_rvalid = 1'b1; bus_rdata = 32'hCAFE_F00D;
    next_cycle();
    bus_rvalid = 1'b0;
    #1;
    chk("both c6 if_rvalid", {31'd0, if_rvalid}, 32'd1);
    chk("both c6 if_rdata", if_rdata, 32'hCAFE_F00D);
    chk("both c6 ls_rdata hold", ls_rdata, 32'h1111_2222);

    // Starvation override with both requests held; bus always ready
    next_cycle();
    if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b0;
    bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h5555_AAAA;
    #1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        next_cycle(); next_cycle(); next_cycle();
        #1;
        chk($sformatf("starve arb%0d ls_rvalid", k), {31'd0, ls_rvalid}, {31'd0, exp_arb_ls[k-1]});
        chk($sformatf("starve arb%0d if_rvalid", k), {31'd0, if_rvalid}, {31'd0, !exp_arb_ls[k-1]});
      end
      chk($sformatf("starve arb%0d ls_gnt", k), {31'd0, ls_gnt}, {31'd0, exp_arb_ls[k]});
      chk($sformatf("starve arb%0d if_gnt", k), {31'd0, if_gnt}, {31'd0, !exp_arb_ls[k]});
    end
    next_cycle();
    if_req = 1'b0; ls_req = 1'b0;
    next_cycle();
    next_cycle();
    bus_rvalid = 1'b0; bus_gnt = 1'b0;
    #1;
    chk("starve tail ls_rvalid", {31'd0, ls_rvalid}, 32'd1);
    // Counter is saturated again after two more LSU wins
    if_req = 1'b1; ls_req = 1'b1;
    #1;
    chk("starve sat if_gnt", {31'd0, if_gnt}, 32'd1);
    chk("starve sat ls_gnt", {31'd0, ls_gnt}, 32'd0);
    #1;
    if_req = 1'b0; ls_req = 1'b0;

    // LSU store with bus_gnt held off; stray bus_rvalid during CMD is ignored
    next_cycle();
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h300; ls_wdata = 32'hA5A5_5A5A; ls_be = 4'b0011;
    #1;
    chk("st c0 ls_gnt", {31'd0, ls_gnt}, 32'd1);
    for (int i = 1; i <= 6; i++) begin
      next_cycle();
      ls_req = 1'b0;
      ls_wdata = 32'hFFFF_FFFF;
      bus_gnt = (i == 6);
      bus_rvalid = (i == 3);
      bus_rdata = 32'h7777_7777;
      #1;
      chk($sformatf("st c%0d bus_req", i), {31'd0, bus_req}, 32'd1);
      chk($sformatf("st c%0d bus_we", i), {31'd0, bus_we}, 32'd1);
      chk($sformatf("st c%0d bus_addr", i), bus_addr, 32'h300);
      chk($sformatf("st c%0d bus_wdata", i), bus_wdata, 32'hA5A5_5A5A);
      chk($sformatf("st c%0d bus_be", i), {28'd0, bus_be}, 32'h3);
      chk($sformatf("st c%0d ls_rvalid", i), {31'd0, ls_rvalid}, 32'd0);
      chk($sformatf("st c%0d stall_mem", i), {31'd0, stall_req_mem}, 32'd1);
    end
    next_cycle();
    bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h0BAD_0BAD;
    #1;
    chk("st c7 bus_req", {31'd0, bus_req}, 32'd0);
    chk("st c7 ls_rvalid", {31'd0, ls_rvalid}, 32'd0);
    next_cycle();
    bus_rvalid = 1'b0;
    #1;
    chk("st c8 ls_rvalid", {31'd0, ls_rvalid}, 32'd1);
    chk("st c8 ls_rdata", ls_rdata, 32'h0BAD_0BAD);
    chk("st c8 if_rdata hold", if_rdata, 32'h5555_AAAA);
    chk("st c8 if_rvalid", {31'd0, if_rvalid}, 32'd0);
    next_cycle();
    #1;
    chk("st c9 ls_rvalid", {31'd0, ls_rvalid}, 32'd0);
    chk_perf("pre-rst", 3, 6, 1);

    // Reset while in RSP, then a late response
    next_cycle();
    if_req = 1'b1; if_addr = 32'h400; bus_gnt = 1'b1;
    #1;
    chk("rsp-rst c0 if_gnt", {31'd0, if_gnt}, 32'd1);
    next_cycle();
    if_req = 1'b0;
    next_cycle();
    #1;
    rst_n = 1'b0;
    #1;
    chk("rsp-rst bus_req", {31'd0, bus_req}, 32'd0);
    chk("rsp-rst bus_addr", bus_addr, 32'd0);
    chk("rsp-rst stall_if", {31'd0, stall_req_if}, 32'd0);
    chk("rsp-rst if_rdata", if_rdata, 32'd0);
    chk("rsp-rst ls_rdata", ls_rdata, 32'd0);
    chk_perf("rsp-rst", 0, 0, 0);
    #3;
    rst_n = 1'b1;
    next_cycle();
    bus_rvalid = 1'b1; bus_rdata = 32'hBAAD_F00D;
    #1;
    chk("late rsp if_rvalid", {31'd0, if_rvalid}, 32'd0);
    chk("late rsp bus_req", {31'd0, bus_req}, 32'd0);
    next_cycle();
    bus_rvalid = 1'b0;
    #1;
    chk("late rsp+1 if_rvalid", {31'd0, if_rvalid}, 32'd0);
    chk("late rsp+1 if_rdata", if_rdata, 32'd0);

    // Fresh traffic after reset: 3 IF and 2 LSU transactions
    do_txn(1'b0, 32'h500, 32'h1234_5678);
    do_txn(1'b1, 32'h600, 32'h8765_4321);
    do_txn(1'b0, 32'h504, 32'h0F0F_0F0F);
    do_txn(1'b1, 32'h604, 32'hF0F0_F0F0);
    do_txn(1'b0, 32'h508, 32'h3C3C_3C3C);
    chk("final ls_rdata hold", ls_rdata, 32'hF0F0_F0F0);
    chk_perf("final", 3, 2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
